// File: rtl/state_machine.sv
// state_machine: OBC liveness checker; clk, reset (sync, active-high), answerOBC[3:0] in; question[3:0], override out; STATE_MACHINE_STATUS_EN adds state_o[1:0], err_cnt_o[3:0]
module state_machine #(
  parameter int ROUND_LEN = 10,
  parameter int ERR_THRESH = 3,
  parameter logic [3:0] SEED = 4'b0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] answerOBC,
  output logic [3:0] question,
  output logic       override
`ifdef STATE_MACHINE_STATUS_EN
  ,
  output logic [1:0] state_o,
  output logic [3:0] err_cnt_o
`endif
);
  typedef enum logic [1:0] {CHECK = 2'd0, RESET_RND = 2'd1, OVERRIDE = 2'd2} state_t;
  localparam logic [3:0] RL = 4'(ROUND_LEN);
  localparam logic [3:0] ET = 4'(ERR_THRESH);
  state_t state, state_n;
  logic [3:0] q_n, iter_cnt, iter_n, err_cnt, err_n, expected, err_sum, iter_inc;
  logic mismatch;
  assign expected = {question[2] ^ question[3], question[1] ^ question[2], question[0] ^ question[1], ~question[0]};
  assign mismatch = answerOBC != expected;
  assign err_sum = err_cnt + {3'd0, mismatch};
  assign iter_inc = iter_cnt + 4'd1;
  always_comb begin
    state_n = CHECK;
    q_n = question;
    iter_n = 4'd0;
    err_n = 4'd0;
    if (state == CHECK) begin
      q_n = {question[2:0], question[3] ^ question[2]};
      iter_n = iter_inc;
      err_n = err_sum;
      state_n = err_sum == ET ? OVERRIDE : iter_inc == RL ? RESET_RND : CHECK;
    end else if (state == OVERRIDE) begin
      state_n = OVERRIDE;
      iter_n = iter_cnt;
      err_n = err_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CHECK;
      question <= SEED;
      iter_cnt <= 4'd0;
      err_cnt <= 4'd0;
      override <= 1'b0;
    end else begin
      state <= state_n;
      question <= q_n;
      iter_cnt <= iter_n;
      err_cnt <= err_n;
      override <= state_n == OVERRIDE;
    end
  end
`ifdef STATE_MACHINE_STATUS_EN
  assign state_o = state;
  assign err_cnt_o = err_cnt;
`endif
endmodule

// File: tb/tb_state_machine.sv
// tb_state_machine: randomized scoreboard bench for state_machine against a round/error-count reference model
module tb_state_machine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] answer = 4'd0;
  logic [3:0] question;
  logic override;
`ifdef STATE_MACHINE_STATUS_EN
  logic [1:0] state_o;
  logic [3:0] err_cnt_o;
`endif
  state_machine dut (
    .clk(clk),
    .reset(reset),
    .answerOBC(answer),
    .question(question),
    .override(override)
`ifdef STATE_MACHINE_STATUS_EN
    ,
    .state_o(state_o),
    .err_cnt_o(err_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] q; logic ov;} exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                           4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
  int idx = 0;
  int checks = 0;
  int errs = 0;
  bit ov = 0;
  bit between = 0;
  function automatic logic [3:0] fexp(logic [3:0] q);
    return {q[2] ^ q[3], q[1] ^ q[2], q[0] ^ q[1], ~q[0]};
  endfunction
  function automatic logic [3:0] right();
    return fexp(seq[idx]);
  endfunction
  function automatic logic [3:0] wrong();
    return fexp(seq[idx]) ^ 4'($urandom_range(1, 15));
  endfunction
  task automatic step(input bit r, input logic [3:0] a);
    @(negedge clk);
    reset = r;
    answer = a;
    if (r) begin
      idx = 0; checks = 0; errs = 0; ov = 0; between = 0;
    end else if (ov) begin
    end else if (between) begin
      between = 0; checks = 0; errs = 0;
    end else begin
      errs += (a != fexp(seq[idx])) ? 1 : 0;
      checks++;
      idx = (idx + 1) % 15;
      if (errs == 3) ov = 1;
      else if (checks == 10) between = 1;
    end
    sb.push_back('{q: seq[idx], ov: ov});
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (question !== e.q) begin
        bad++;
        $display("FAIL question: got %b want %b at %0t", question, e.q, $time);
      end
      total++;
      if (override !== e.ov) begin
        bad++;
        $display("FAIL override: got %b want %b at %0t", override, e.ov, $time);
      end
    end
  end
  initial begin
    step(1, 4'd0);
    for (int i = 0; i < 100; i++) step(0, right());
    step(1, 4'd0);
    for (int i = 0; i < 6; i++) step(0, 4'b0000);
    step(1, 4'd0);
    step(0, right());
    step(0, wrong());
    step(0, wrong());
    for (int i = 0; i < 8; i++) step(0, right());
    step(0, wrong());
    step(0, wrong());
    step(0, wrong());
    for (int i = 0; i < 12; i++) step(0, right());
    step(0, wrong());
    step(0, wrong());
    step(0, wrong());
    step(0, right());
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = $urandom_range(0, 59) == 0;
      step(r, ($urandom_range(0, 7) == 0) ? wrong() : right());
    end
    step(0, right());
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
